// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small output FIFO.
// Serial bytes are synchronized, deframed and queued for a valid/ready consumer.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [FIFO_AW:0] PTR_ONE =
    (FIFO_AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t          state, state_nx;
  logic            rxd_m, rxd_s;
  logic [CW-1:0]   bit_cnt, bit_cnt_nx;
  logic [2:0]      bit_idx, bit_idx_nx;
  logic [7:0]      shreg, shreg_nx;
  logic            push, ferr;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             empty, full, pop, wr_en;

  // Two-flop synchronizer, idle-high after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Receiver state, baud counter, bit index and shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
    end
  end

  // Next-state logic; push/ferr fire on the stop-bit sample
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = (bit_cnt == LAST) ? '0
                                   : bit_cnt + CNT_ONE;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    push       = 1'b0;
    ferr       = 1'b0;
    unique case (state)
      IDLE: begin
        bit_cnt_nx = '0;
        if (!rxd_s) state_nx = START;
      end
      START: begin
        if (bit_cnt == HALF) begin
          if (rxd_s) begin
            state_nx = IDLE;
          end else begin
            state_nx   = DATA;
            bit_cnt_nx = '0;
            bit_idx_nx = '0;
          end
        end
      end
      DATA: begin
        if (bit_cnt == LAST) begin
          shreg_nx   = {rxd_s, shreg[7:1]};
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (bit_cnt == LAST) begin
          if (rxd_s) begin
            push     = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr     = 1'b1;
            state_nx = BRK;
          end
        end
      end
      BRK: begin
        bit_cnt_nx = '0;
        if (rxd_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  =
    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]) &&
    (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);
  assign pop   = !empty && rx_ready;
  assign wr_en = push && (!full || pop);

  assign rx_valid = !empty;
  assign rx_data  = mem[rd_ptr[FIFO_AW-1:0]];

  // FIFO storage and pointers; a same-cycle pop makes room
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Registered error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= push && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo.
// Driver queues expected bytes; a negedge monitor checks every pop.
module tb_uart_rx_fifo;

  localparam int CPB = 16;
  localparam int AW  = 2;
  localparam int TMO = 40 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;

  int passed = 0;
  int total  = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q [$];

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input int got,
                       input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s got=%0h required=%0h",
                  name, got, want);
  endtask

  // Monitor: count pulses, compare each popped byte
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL pop_unexpected got=%0h required=none",
                   rx_data);
        end else begin
          check("pop_data", int'(rx_data),
                int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] d,
                           input logic stopb);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stopb);
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(posedge clk);
    #1;
    send_bits(d, 1'b1);
  endtask

  task automatic pop_one();
    int n = 0;
    while (!rx_valid && n < TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rx_valid) begin
      total++;
      $display("FAIL pop_timeout got=valid0 required=valid1");
    end else begin
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    // 1 reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_data", int'(rx_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20 * CPB) @(posedge clk);
    #1;
    check("idle_valid", int'(rx_valid), 0);

    // 2 single byte
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    check("single_valid", int'(rx_valid), 1);
    pop_one();
    @(negedge clk);
    check("single_empty", int'(rx_valid), 0);

    // 3 burst into full FIFO
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_byte(8'(i));
    end
    check("burst_ovr", ov_cnt, 1);
    for (int i = 0; i < 4; i++) pop_one();
    @(negedge clk);
    check("burst_empty", int'(rx_valid), 0);

    // 4 framing error then recovery
    @(posedge clk);
    #1;
    send_bits(8'h3C, 1'b0);
    repeat (3) drive_bit(1'b0);
    drive_bit(1'b1);
    check("frame_cnt", fe_cnt, 1);
    check("frame_nopush", int'(rx_valid), 0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A);
    pop_one();

    // 5 glitch
    fe0 = fe_cnt;
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    check("glitch_nopush", int'(rx_valid), 0);
    check("glitch_noerr", fe_cnt, fe0);
    exp_q.push_back(8'h96);
    send_byte(8'h96);
    pop_one();

    // 6 push and pop on the same edge while full
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i * 8'h11));
      send_byte(8'(i * 8'h11));
    end
    exp_q.push_back(8'h55);
    @(posedge clk);
    #1;
    fork
      send_bits(8'h55, 1'b1);
      begin
        repeat (10 * CPB - 6) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    check("simul_noovr", ov_cnt, 1);
    check("simul_valid", int'(rx_valid), 1);
    for (int i = 0; i < 4; i++) pop_one();
    @(negedge clk);
    check("simul_empty", int'(rx_valid), 0);

    // reset mid-DATA flushes the FIFO
    exp_q.push_back(8'h77);
    send_byte(8'h77);
    check("pre_rst_valid", int'(rx_valid), 1);
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12 * CPB) @(posedge clk);
    #1;
    check("rst_flush", int'(rx_valid), 0);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3);
    pop_one();
    @(negedge clk);
    check("final_empty", int'(rx_valid), 0);
    check("final_q", exp_q.size(), 0);
    check("final_ovr", ov_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
